// File: rtl/f_bpred_npc_if.sv
// Fetch/decode-side signals exchanged between the pipeline and the next-PC unit.
// The pipeline drives the master side; the next-PC unit sits on the slave side.
interface f_bpred_npc_if #(
  parameter int CNT_W = 16
);
  logic             stall_F;
  logic [31:0]      pc_F;
  logic             pred_taken_F;
  logic [31:0]      pred_target_F;
  logic             valid_D;
  logic [31:0]      pc_D;
  logic             is_b_D;
  logic             is_j_D;
  logic             is_jr_D;
  logic             taken_D;
  logic [31:0]      target_D;
  logic             pred_taken_D;
  logic [31:0]      pred_target_D;
  logic             flush_D;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output stall_F, valid_D, pc_D, is_b_D, is_j_D, is_jr_D, taken_D, target_D,
           pred_taken_D, pred_target_D,
    input  pc_F, pred_taken_F, pred_target_F, flush_D, mispred_cnt
  );

  modport slave (
    input  stall_F, valid_D, pc_D, is_b_D, is_j_D, is_jr_D, taken_D, target_D,
           pred_taken_D, pred_target_D,
    output pc_F, pred_taken_F, pred_target_F, flush_D, mispred_cnt
  );
endinterface

// File: rtl/f_bpred_npc.sv
// Fetch PC register and next-PC unit: direct-mapped BTB with 2-bit counters,
// verified against decode-stage resolution, or legacy delay-slot redirect.
module f_bpred_npc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          ENTRIES    = 16,
  parameter bit          DELAY_SLOT = 1'b0,
  parameter int          CNT_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  f_bpred_npc_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]      pc_reg, pc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [ENTRIES-1:0] valid_vec;
  logic [1:0]         ctr_vec [ENTRIES];
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];

  // Fetch-side lookup
  logic [IDX_W-1:0] idx_f;
  logic             hit_f;
  logic [31:0]      pc_plus4;
  logic             pred_taken;
  logic [31:0]      pred_target;

  assign idx_f       = pc_reg[IDX_W+1:2];
  assign hit_f       = valid_vec[idx_f] && (tag_mem[idx_f] == pc_reg[31:IDX_W+2]);
  assign pc_plus4    = pc_reg + 32'd4;
  assign pred_taken  = !DELAY_SLOT && hit_f && ctr_vec[idx_f][1];
  assign pred_target = pred_taken ? target_mem[idx_f] : pc_plus4;

  // Decode-side resolution
  logic        resolve;
  logic        is_ctl;
  logic        act_taken;
  logic [31:0] act_npc;
  logic        mispredict;

  assign resolve    = bus.valid_D && !bus.stall_F;
  assign is_ctl     = bus.is_b_D || bus.is_j_D || bus.is_jr_D;
  assign act_taken  = bus.is_j_D || bus.is_jr_D || (bus.is_b_D && bus.taken_D);
  assign act_npc    = act_taken ? bus.target_D : (bus.pc_D + 32'd4);
  assign mispredict = !DELAY_SLOT && resolve &&
                      ((bus.pred_taken_D != act_taken) ||
                       (act_taken && (bus.pred_target_D != bus.target_D)));

  always_comb begin
    pc_next = pc_reg;
    if (DELAY_SLOT) begin
      if (!bus.stall_F)
        pc_next = (resolve && act_taken) ? bus.target_D : pc_plus4;
    end else if (mispredict) begin
      pc_next = act_npc;
    end else if (!bus.stall_F) begin
      pc_next = pred_target;
    end
  end

  assign cnt_next = (mispredict && (cnt_reg != {CNT_W{1'b1}})) ? cnt_reg + CNT_W'(1) : cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg  <= RESET_PC;
      cnt_reg <= '0;
    end else begin
      pc_reg  <= pc_next;
      cnt_reg <= cnt_next;
    end
  end

  // BTB update decode; jumps win over branches if both flags are ever raised
  logic [IDX_W-1:0] idx_d;
  logic [TAG_W-1:0] tag_d;
  logic             hit_d;
  logic             btb_upd;
  logic             j_op, b_op;
  logic             wr_alloc, wr_target, ctr_we, inval;
  logic [1:0]       ctr_cur, ctr_new;

  assign idx_d   = bus.pc_D[IDX_W+1:2];
  assign tag_d   = bus.pc_D[31:IDX_W+2];
  assign hit_d   = valid_vec[idx_d] && (tag_mem[idx_d] == tag_d);
  assign btb_upd = !DELAY_SLOT && resolve;
  assign j_op    = bus.is_j_D;
  assign b_op    = bus.is_b_D && !bus.is_j_D && !bus.is_jr_D;
  assign ctr_cur = ctr_vec[idx_d];

  assign wr_alloc  = btb_upd && (j_op || (b_op && !hit_d && bus.taken_D));
  assign wr_target = wr_alloc || (btb_upd && b_op && hit_d && bus.taken_D);
  assign ctr_we    = wr_alloc || (btb_upd && b_op && hit_d);
  assign inval     = btb_upd && !is_ctl && hit_d;

  always_comb begin
    ctr_new = ctr_cur;
    if (j_op)
      ctr_new = 2'b11;
    else if (!hit_d)
      ctr_new = 2'b10;
    else if (bus.taken_D)
      ctr_new = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
    else
      ctr_new = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic       valid_reg;
      logic [1:0] ctr_reg;
      logic       sel;

      assign sel = (idx_d == IDX_W'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_reg <= 1'b0;
          ctr_reg   <= 2'b01;
        end else if (sel) begin
          if (wr_alloc)
            valid_reg <= 1'b1;
          else if (inval)
            valid_reg <= 1'b0;
          if (ctr_we)
            ctr_reg <= ctr_new;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign ctr_vec[gi]   = ctr_reg;
    end
  endgenerate

  // Tag/target payload is qualified by valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (wr_alloc)
      tag_mem[idx_d] <= tag_d;
    if (wr_target)
      target_mem[idx_d] <= bus.target_D;
  end

  assign bus.pc_F          = pc_reg;
  assign bus.pred_taken_F  = pred_taken;
  assign bus.pred_target_F = pred_target;
  assign bus.flush_D       = mispredict;
  assign bus.mispred_cnt   = cnt_reg;
endmodule

// File: tb/tb_f_bpred_npc.sv
// Bench for f_bpred_npc: directed vector table, mid-run reset, random stimulus
// against an address-keyed BTB model, and a delay-slot instance checked alongside.
module tb_f_bpred_npc;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  f_bpred_npc_if #(.CNT_W(CW)) bus ();
  f_bpred_npc_if #(.CNT_W(CW)) bus_ds ();

  f_bpred_npc #(.RESET_PC(32'h0000_3000), .ENTRIES(16), .DELAY_SLOT(1'b0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  f_bpred_npc #(.RESET_PC(32'h0000_3000), .ENTRIES(16), .DELAY_SLOT(1'b1), .CNT_W(CW)) dut_ds (
    .clk(clk), .reset(reset), .bus(bus_ds));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(logic st, logic v, logic [31:0] pcd, logic b, logic j, logic jr,
                       logic tk, logic [31:0] tgt, logic ptk, logic [31:0] ptgt);
    bus.stall_F = st;      bus_ds.stall_F = st;
    bus.valid_D = v;       bus_ds.valid_D = v;
    bus.pc_D = pcd;        bus_ds.pc_D = pcd;
    bus.is_b_D = b;        bus_ds.is_b_D = b;
    bus.is_j_D = j;        bus_ds.is_j_D = j;
    bus.is_jr_D = jr;      bus_ds.is_jr_D = jr;
    bus.taken_D = tk;      bus_ds.taken_D = tk;
    bus.target_D = tgt;    bus_ds.target_D = tgt;
    bus.pred_taken_D = ptk;   bus_ds.pred_taken_D = ptk;
    bus.pred_target_D = ptgt; bus_ds.pred_target_D = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  typedef struct {
    logic        st, v;
    logic [31:0] pcd;
    logic        b, j, jr, tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic [31:0] e_pc;
    logic        e_ptk;
    logic [31:0] e_ptgt;
    logic        e_flush;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(logic st, logic v, logic [31:0] pcd, logic b, logic j, logic jr,
                              logic tk, logic [31:0] tgt, logic ptk, logic [31:0] ptgt,
                              logic [31:0] e_pc, logic e_ptk, logic [31:0] e_ptgt,
                              logic e_flush, int e_cnt);
    vec_t r;
    r.st = st; r.v = v; r.pcd = pcd; r.b = b; r.j = j; r.jr = jr; r.tk = tk;
    r.tgt = tgt; r.ptk = ptk; r.ptgt = ptgt;
    r.e_pc = e_pc; r.e_ptk = e_ptk; r.e_ptgt = e_ptgt; r.e_flush = e_flush; r.e_cnt = e_cnt;
    return r;
  endfunction

  // Reference model: each slot remembers the full PC that owns it
  bit          m_valid [16];
  logic [31:0] m_owner [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_pc, d_pc;
  int          m_cnt;

  function automatic int ix(logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    return m_valid[ix(a)] && (m_owner[ix(a)] == a);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_pc  = 32'h3000;
    d_pc  = 32'h3000;
    m_cnt = 0;
  endtask

  function automatic logic [31:0] rpc();
    return 32'h3000 + 32'($urandom_range(0, 47)) * 32'd4;
  endfunction

  vec_t tbl [15];

  initial begin
    logic        st, v, b, j, jr, tk, ptk, e_ptk, resolve, act, misp, h;
    logic [31:0] pcd, tgt, ptgt, e_ptgt, npc, prev_pc, prev_ptgt;
    logic        prev_ptk;
    int          kind, k;

    tbl[0]  = mk(0,0,32'h0,   0,0,0,0,32'h0,   0,32'h0,    32'h3000,0,32'h3004,0,0);
    tbl[1]  = mk(0,1,32'h3000,1,0,0,1,32'h3010,0,32'h3004, 32'h3004,0,32'h3008,1,0);
    tbl[2]  = mk(0,0,32'h0,   0,0,0,0,32'h0,   0,32'h0,    32'h3010,0,32'h3014,0,1);
    tbl[3]  = mk(0,1,32'h3010,0,1,0,0,32'h3000,0,32'h3014, 32'h3014,0,32'h3018,1,1);
    tbl[4]  = mk(0,0,32'h0,   0,0,0,0,32'h0,   0,32'h0,    32'h3000,1,32'h3010,0,2);
    tbl[5]  = mk(0,1,32'h3000,1,0,0,1,32'h3010,1,32'h3010, 32'h3010,1,32'h3000,0,2);
    tbl[6]  = mk(1,1,32'h3010,0,1,0,0,32'h3000,0,32'h3014, 32'h3000,1,32'h3010,0,2);
    tbl[7]  = mk(0,1,32'h3010,0,1,0,0,32'h3000,0,32'h3014, 32'h3000,1,32'h3010,1,2);
    tbl[8]  = mk(0,1,32'h3020,0,0,1,0,32'h3400,0,32'h3024, 32'h3000,1,32'h3010,1,3);
    tbl[9]  = mk(0,1,32'h3020,0,0,1,0,32'h3400,0,32'h3024, 32'h3400,0,32'h3404,1,4);
    tbl[10] = mk(0,1,32'h3000,0,0,0,0,32'h0,   1,32'h3010, 32'h3400,0,32'h3404,1,5);
    tbl[11] = mk(0,0,32'h0,   0,0,0,0,32'h0,   0,32'h0,    32'h3004,0,32'h3008,0,6);
    tbl[12] = mk(0,1,32'h3004,0,1,0,0,32'h3000,0,32'h3008, 32'h3008,0,32'h300c,1,6);
    tbl[13] = mk(0,1,32'h3000,1,0,0,1,32'h3010,0,32'h3004, 32'h3000,0,32'h3004,1,7);
    tbl[14] = mk(0,0,32'h0,   0,0,0,0,32'h0,   0,32'h0,    32'h3010,1,32'h3000,0,8);

    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_pc", bus.pc_F, 32'h3000);
    check("rst_cnt", 32'(bus.mispred_cnt), 32'd0);
    check("rst_pred_tgt", bus.pred_target_F, 32'h3004);
    check("rst_ds_pc", bus_ds.pc_F, 32'h3000);
    reset = 1'b1;

    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].st, tbl[r].v, tbl[r].pcd, tbl[r].b, tbl[r].j, tbl[r].jr,
            tbl[r].tk, tbl[r].tgt, tbl[r].ptk, tbl[r].ptgt);
      #1;
      check($sformatf("vec%0d_pc", r), bus.pc_F, tbl[r].e_pc);
      check($sformatf("vec%0d_ptk", r), 32'(bus.pred_taken_F), 32'(tbl[r].e_ptk));
      check($sformatf("vec%0d_ptgt", r), bus.pred_target_F, tbl[r].e_ptgt);
      check($sformatf("vec%0d_flush", r), 32'(bus.flush_D), 32'(tbl[r].e_flush));
      check($sformatf("vec%0d_cnt", r), 32'(bus.mispred_cnt), 32'(tbl[r].e_cnt));
      $display("vec %0d: pc_F=%h pred=%0d/%h flush=%0d cnt=%0d", r, bus.pc_F,
               bus.pred_taken_F, bus.pred_target_F, bus.flush_D, bus.mispred_cnt);
      @(negedge clk);
    end

    // Reset asserted while a redirect is pending
    idle();
    #1;
    check("pre_rst_pred", bus.pred_target_F, 32'h3010);
    @(negedge clk);
    drive(0, 1, 32'h3010, 0, 1, 0, 0, 32'h3500, 0, 32'h3014);
    #1;
    check("pre_rst_pc", bus.pc_F, 32'h3010);
    check("pre_rst_flush", 32'(bus.flush_D), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_pc", bus.pc_F, 32'h3000);
    check("midrst_cnt", 32'(bus.mispred_cnt), 32'd0);
    @(negedge clk);
    check("midrst_hold_pc", bus.pc_F, 32'h3000);
    idle();
    reset = 1'b1;
    #1;
    check("post_rst_ptk", 32'(bus.pred_taken_F), 32'd0);
    check("post_rst_pred", bus.pred_target_F, 32'h3004);
    $display("mid-run reset: pc_F=%h pred_target_F=%h", bus.pc_F, bus.pred_target_F);

    m_reset();
    prev_pc = 32'h3000; prev_ptk = 1'b0; prev_ptgt = 32'h3004;
    for (int it = 0; it < 500; it++) begin
      kind = int'($urandom_range(0, 3));
      b  = (kind == 1); j = (kind == 2); jr = (kind == 3);
      tk = 1'($urandom_range(0, 1));
      v  = (it != 0) && ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 1) == 1) begin
        pcd = prev_pc; ptk = prev_ptk; ptgt = prev_ptgt;
      end else begin
        pcd  = rpc();
        ptk  = 1'($urandom_range(0, 1));
        ptgt = ptk ? rpc() : pcd + 32'd4;
      end
      tgt = (ptk && $urandom_range(0, 1) == 1) ? ptgt : rpc();
      drive(st, v, pcd, b, j, jr, tk, tgt, ptk, ptgt);
      #1;

      e_ptk   = m_hit(m_pc) && (m_ctr[ix(m_pc)] >= 2);
      e_ptgt  = e_ptk ? m_tgt[ix(m_pc)] : m_pc + 32'd4;
      resolve = v && !st;
      act     = j || jr || (b && tk);
      npc     = act ? tgt : pcd + 32'd4;
      misp    = resolve && ((ptk != act) || (act && (ptgt != tgt)));

      check("rnd_pc", bus.pc_F, m_pc);
      check("rnd_ptk", 32'(bus.pred_taken_F), 32'(e_ptk));
      check("rnd_ptgt", bus.pred_target_F, e_ptgt);
      check("rnd_flush", 32'(bus.flush_D), 32'(misp));
      check("rnd_cnt", 32'(bus.mispred_cnt), 32'(m_cnt));
      check("ds_pc", bus_ds.pc_F, d_pc);
      check("ds_ptk", 32'(bus_ds.pred_taken_F), 32'd0);
      check("ds_flush", 32'(bus_ds.flush_D), 32'd0);
      check("ds_cnt", 32'(bus_ds.mispred_cnt), 32'd0);
      $display("rnd %0d: pc_F=%h D(v=%0d st=%0d pc=%h k=%0d tk=%0d) flush=%0d cnt=%0d ds_pc=%h",
               it, bus.pc_F, v, st, pcd, kind, tk, bus.flush_D, bus.mispred_cnt, bus_ds.pc_F);

      prev_pc = m_pc; prev_ptk = e_ptk; prev_ptgt = e_ptgt;
      if (!st) d_pc = (resolve && act) ? tgt : d_pc + 32'd4;
      if (misp) m_pc = npc;
      else if (!st) m_pc = e_ptgt;
      if (misp && m_cnt < MAXC) m_cnt++;
      if (resolve) begin
        k = ix(pcd);
        h = m_hit(pcd);
        if (j) begin
          m_valid[k] = 1'b1; m_owner[k] = pcd; m_tgt[k] = tgt; m_ctr[k] = 3;
        end else if (b) begin
          if (h) begin
            if (tk) begin
              if (m_ctr[k] < 3) m_ctr[k]++;
              m_tgt[k] = tgt;
            end else if (m_ctr[k] > 0) begin
              m_ctr[k]--;
            end
          end else if (tk) begin
            m_valid[k] = 1'b1; m_owner[k] = pcd; m_tgt[k] = tgt; m_ctr[k] = 2;
          end
        end else if (!jr && h) begin
          m_valid[k] = 1'b0;
        end
      end
      @(negedge clk);
    end

    // Legacy delay-slot sequence
    reset = 1'b0;
    idle();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ds_seq_pc0", bus_ds.pc_F, 32'h3000);
    @(negedge clk);
    drive(0, 1, 32'h3000, 1, 0, 0, 1, 32'h3100, 0, 32'h3004);
    #1;
    check("ds_seq_pc1", bus_ds.pc_F, 32'h3004);
    check("ds_seq_flush", 32'(bus_ds.flush_D), 32'd0);
    check("ds_seq_ptk", 32'(bus_ds.pred_taken_F), 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("ds_seq_pc2", bus_ds.pc_F, 32'h3100);
    check("ds_seq_cnt", 32'(bus_ds.mispred_cnt), 32'd0);
    $display("delay-slot: pc_F=%h flush_D=%0d", bus_ds.pc_F, bus_ds.flush_D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
